// File: rtl/alu_pkg.sv
// Shared constants and FSM encoding for the ALU command issuer.
package alu_pkg;

  localparam int OPND_W = 4;
  localparam int RES_W  = 8;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_SLT = 3'd5;
  localparam logic [OP_W-1:0] OP_MUL = 3'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Bundle of the command, ALU and response channels of the issuer, plus debug visibility.
interface alu_cmd_issuer_if #(
  parameter int ID_W = 4
);
  import alu_pkg::*;

  // Every channel: a transfer happens in a cycle where valid && ready; once valid
  // is raised, payload stays stable until that transfer. alu_out_valid is the one
  // exception: a single-cycle pulse that cannot be stalled.
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OPND_W-1:0] cmd_a;
  logic [OPND_W-1:0] cmd_b;
  logic [OP_W-1:0]   cmd_op;

  logic              alu_in_valid;
  logic              alu_in_ready;
  logic [OPND_W-1:0] alu_a;
  logic [OPND_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic              alu_out_valid;
  logic [RES_W-1:0]  alu_result;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [RES_W-1:0]  rsp_data;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_timeout;

  logic              busy;
  state_t            dbg_state;
  logic [7:0]        dbg_rsp_level;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    input  alu_in_ready, alu_out_valid, alu_result,
    input  rsp_ready,
    output cmd_ready, alu_in_valid, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_data, rsp_id, rsp_timeout,
    output busy, dbg_state, dbg_rsp_level
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    output alu_in_ready, alu_out_valid, alu_result,
    output rsp_ready,
    input  cmd_ready, alu_in_valid, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_data, rsp_id, rsp_timeout,
    input  busy, dbg_state, dbg_rsp_level
  );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is taken only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  // Head reads as zero when empty so downstream outputs are clean after reset.
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, issues them one at a time, tags results with a sequence id
// and buffers them for a downstream consumer; a hung ALU yields a timeout response.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int ID_W      = 4,
  parameter int TIMEOUT   = 15
) (
  input logic              clk,
  input logic              rst,
  alu_cmd_issuer_if.master bus
);

  localparam int CMD_W = 2 * OPND_W + OP_W;
  localparam int RSP_W = RES_W + ID_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t                   r_state;
  logic                     r_alu_in_valid;
  logic [ID_W-1:0]          r_next_id;
  logic [TMR_W-1:0]         r_timer;

  logic                     w_cmd_push;
  logic                     w_cmd_full;
  logic                     w_cmd_empty;
  logic [$clog2(CMD_DEPTH):0] w_cmd_count;
  logic [CMD_W-1:0]         w_cmd_rdata;
  logic                     w_issue_hs;

  logic                     w_rsp_push;
  logic                     w_rsp_pop;
  logic                     w_rsp_full;
  logic                     w_rsp_empty;
  logic                     w_rsp_slot;
  logic [$clog2(RSP_DEPTH):0] w_rsp_count;
  logic [RSP_W-1:0]         w_rsp_wdata;
  logic [RSP_W-1:0]         w_rsp_rdata;
  logic                     w_done;
  logic                     w_tmo;

  assign w_cmd_push = bus.cmd_valid && !w_cmd_full;
  assign w_issue_hs = r_alu_in_valid && bus.alu_in_ready;

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_cmd_push),
    .i_wdata ({bus.cmd_a, bus.cmd_b, bus.cmd_op}),
    .i_pop   (w_issue_hs),
    .o_rdata (w_cmd_rdata),
    .o_full  (w_cmd_full),
    .o_empty (w_cmd_empty),
    .o_count (w_cmd_count)
  );

  // A result pulse cannot wait, so a response slot is reserved before issuing;
  // a pop in the same cycle frees a slot just as well.
  assign w_rsp_pop   = !w_rsp_empty && bus.rsp_ready;
  assign w_rsp_slot  = !w_rsp_full || w_rsp_pop;
  assign w_done      = (r_state == WAIT) && bus.alu_out_valid;
  assign w_tmo       = (r_state == WAIT) && !bus.alu_out_valid && (r_timer == TMR_LAST);
  assign w_rsp_push  = w_done || w_tmo;
  assign w_rsp_wdata = w_done ? {bus.alu_result, r_next_id, 1'b0}
                              : {{RES_W{1'b0}}, r_next_id, 1'b1};

  sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rsp_push),
    .i_wdata (w_rsp_wdata),
    .i_pop   (w_rsp_pop),
    .o_rdata (w_rsp_rdata),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty),
    .o_count (w_rsp_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_alu_in_valid <= 1'b0;
      r_next_id      <= '0;
      r_timer        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_cmd_empty && w_rsp_slot) begin
            r_state        <= ISSUE;
            r_alu_in_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (bus.alu_in_ready) begin
            r_state        <= WAIT;
            r_alu_in_valid <= 1'b0;
            r_timer        <= '0;
          end
        end
        WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (w_rsp_push) begin
            r_state   <= IDLE;
            r_next_id <= r_next_id + 1'b1;
          end
        end
        default: begin
          r_state        <= IDLE;
          r_alu_in_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready     = !w_cmd_full;
  assign bus.alu_in_valid  = r_alu_in_valid;
  assign {bus.alu_a, bus.alu_b, bus.alu_op} = w_cmd_rdata;
  assign bus.rsp_valid     = !w_rsp_empty;
  assign {bus.rsp_data, bus.rsp_id, bus.rsp_timeout} = w_rsp_rdata;
  assign bus.busy          = (r_state != IDLE) || (w_cmd_count != '0);
  assign bus.dbg_state     = r_state;
  assign bus.dbg_rsp_level = 8'(w_rsp_count);

endmodule
